fft_window: RTL and testbench

//  Applies a programmable window (Hann/Hamming/rect) to real ADC samples before fft_core.

---
 rtl/fft_window_pkg.sv | 55 +++++
 rtl/fft_window_mul.sv | 90 +++++++++
 rtl/fft_window.sv | 102 ++++++++++
 tb/tb_fft_window.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_window_pkg.sv
// fft_window shared types and arithmetic
// Window rounding/saturation helpers used by the pipeline
package fft_window_pkg;

  localparam int WMAX = 32;
  localparam int UNITY = 2 ** 15 - 1;

  typedef struct packed {
    logic signed [WMAX-1:0] data;
    logic                   last;
    logic                   sat;
  } win_beat_t;

  function automatic logic [WMAX-1:0] win_unity(input int cw);
    return WMAX'((64'sd1 <<< (cw - 1)) - 64'sd1);
  endfunction

  // Round half up, shift back to Q1.x, clip to dw bits
  function automatic logic [WMAX:0] win_sat_prod(
    input logic signed [2*WMAX-1:0] p,
    input int                       dw,
    input int                       cw
  );
    logic signed [2*WMAX-1:0] r;
    logic signed [2*WMAX-1:0] hi;
    logic signed [2*WMAX-1:0] lo;
    logic                     sat;
    logic [WMAX-1:0]          res;
    r   = (p + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    res = r[WMAX-1:0];
    if (r > hi) begin
      res = hi[WMAX-1:0];
      sat = 1'b1;
    end else if (r < lo) begin
      res = lo[WMAX-1:0];
      sat = 1'b1;
    end
    return {sat, res};
  endfunction

  function automatic logic [WMAX:0] win_round_sat(
    input logic signed [WMAX-1:0] data,
    input logic signed [WMAX-1:0] coef,
    input int                     dw,
    input int                     cw
  );
    logic signed [2*WMAX-1:0] p;
    p = (2*WMAX)'(data) * (2*WMAX)'(coef);
    return win_sat_prod(p, dw, cw);
  endfunction

endpackage

// File: rtl/fft_window_mul.sv
// fft_window two-stage multiply pipeline
// S1 holds the product, S2 the rounded/saturated beat
module fft_window_mul
  import fft_window_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         adv1_i,
  input  logic                         adv2_i,
  input  logic                         in_fire_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic signed [COEF_WIDTH-1:0] coef_i,
  input  logic                         bypass_i,
  input  logic                         last_i,
  output logic                         s1_valid_o,
  output logic                         valid_o,
  output win_beat_t                    beat_o
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  logic                         s1_valid_q;
  logic signed [PW-1:0]         s1_prod_q;
  logic signed [DATA_WIDTH-1:0] s1_data_q;
  logic                         s1_byp_q;
  logic                         s1_last_q;
  logic                         s2_valid_q;
  win_beat_t                    s2_q;
  win_beat_t                    s2_d;
  logic [WMAX:0]                rs;

  // S1 valid: loads on advance, cleared by flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (adv1_i) begin
      s1_valid_q <= in_fire_i;
    end
  end

  // S1 payload: product plus raw sample for bypass
  always_ff @(posedge clk_i) begin
    if (adv1_i && in_fire_i) begin
      s1_prod_q <= data_i * coef_i;
      s1_data_q <= data_i;
      s1_byp_q  <= bypass_i;
      s1_last_q <= last_i;
    end
  end

  // S2 next beat: round/saturate or pass through
  always_comb begin
    rs = win_sat_prod(
      {{(2*WMAX-PW){s1_prod_q[PW-1]}}, s1_prod_q},
      DATA_WIDTH, COEF_WIDTH);
    s2_d.last = s1_last_q;
    if (s1_byp_q) begin
      s2_d.data = {{(WMAX-DATA_WIDTH){s1_data_q[DATA_WIDTH-1]}},
                   s1_data_q};
      s2_d.sat  = 1'b0;
    end else begin
      s2_d.data = rs[WMAX-1:0];
      s2_d.sat  = rs[WMAX];
    end
  end

  // S2 register: payload only moves when a beat arrives
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (flush_i) begin
      s2_valid_q <= 1'b0;
    end else if (adv2_i) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= s2_d;
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign valid_o    = s2_valid_q;
  assign beat_o     = s2_q;

endmodule

// File: rtl/fft_window.sv
// fft_window: windowing stage in front of fft_core
// Coef table, frame index, bypass latch and handshake
module fft_window
  import fft_window_pkg::*;
#(
  parameter int FFT_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_WIDTH-1:0]       s_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic                        m_last_o,
  input  logic                        bypass_i,
  input  logic                        flush_i,
  input  logic                        coef_we_i,
  input  logic [$clog2(FFT_SIZE)-1:0] coef_addr_i,
  input  logic [COEF_WIDTH-1:0]       coef_data_i,
  output logic                        sat_o
);

  localparam int AW = $clog2(FFT_SIZE);
  localparam logic [COEF_WIDTH-1:0] UNITY_C =
    COEF_WIDTH'(win_unity(COEF_WIDTH));

  logic [COEF_WIDTH-1:0] coef_q [FFT_SIZE];
  logic [AW-1:0]         idx_q;
  logic [AW-1:0]         idx_d;
  logic                  byp_q;
  logic                  byp_cur;
  logic                  adv1;
  logic                  adv2;
  logic                  s1_valid;
  logic                  in_fire;
  logic                  first;
  win_beat_t             beat;
  logic                  unused_hi;

  assign adv2      = !m_valid_o || m_ready_i;
  assign adv1      = !s1_valid || adv2;
  assign s_ready_o = adv1 && !rst_i && !flush_i;
  assign in_fire   = s_valid_i && s_ready_o;
  assign first     = (idx_q == '0);
  assign byp_cur   = first ? bypass_i : byp_q;

  // Coefficient table; a write lands after this cycle's read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FFT_SIZE; i++) coef_q[i] <= UNITY_C;
    end else if (coef_we_i) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  // Next frame index: flush restarts, accepts advance
  always_comb begin
    idx_d = idx_q;
    if (flush_i) idx_d = '0;
    else if (in_fire) idx_d = idx_q + AW'(1);
  end

  // Index counter and per-frame bypass latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      byp_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      if (in_fire && first) byp_q <= bypass_i;
    end
  end

  fft_window_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .COEF_WIDTH(COEF_WIDTH)
  ) u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .adv1_i     (adv1),
    .adv2_i     (adv2),
    .in_fire_i  (in_fire),
    .data_i     (s_data_i),
    .coef_i     (coef_q[idx_q]),
    .bypass_i   (byp_cur),
    .last_i     (idx_q == AW'(FFT_SIZE - 1)),
    .s1_valid_o (s1_valid),
    .valid_o    (m_valid_o),
    .beat_o     (beat)
  );

  assign m_data_o  = beat.data[DATA_WIDTH-1:0];
  assign m_last_o  = m_valid_o && beat.last;
  assign sat_o     = m_valid_o && m_ready_i && beat.sat;
  assign unused_hi = ^beat.data[WMAX-1:DATA_WIDTH];

endmodule

// File: tb/tb_fft_window.sv
// fft_window bench: random traffic vs queue model
// Directed frames for Hann, saturation, bypass, flush
module tb_fft_window;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic          m_last_o;
  logic          bypass_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          coef_we_i = 1'b0;
  logic [AW-1:0] coef_addr_i = '0;
  logic [CW-1:0] coef_data_i = '0;
  logic          sat_o;

  always #5 clk_i = ~clk_i;

  fft_window #(.FFT_SIZE(N), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_last_o(m_last_o), .bypass_i(bypass_i), .flush_i(flush_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i),
    .coef_data_i(coef_data_i), .sat_o(sat_o)
  );

  typedef struct {
    int data;
    bit last;
    bit sat;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   src[$];
  int   cap_d[$];
  bit   cap_l[$];
  bit   cap_s[$];
  int   mcoef[N];
  int   midx;
  bit   mbyp;
  int   cyc;
  bit   lat_en;
  int   n_chk;
  int   n_err;

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    midx = 0;
    mbyp = 1'b0;
    foreach (mcoef[i]) mcoef[i] = 32767;
  endfunction

  function automatic exp_t model_beat(int d, bit byp, int c, int idx);
    exp_t   e;
    longint r;
    e.last = (idx == N - 1);
    e.sat  = 1'b0;
    e.cyc  = cyc;
    if (byp) begin
      e.data = d;
    end else begin
      r = (longint'(d) * longint'(c) + 16384) >>> 15;
      if (r > 32767) begin
        r = 32767;
        e.sat = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        e.sat = 1'b1;
      end
      e.data = int'(r);
    end
    return e;
  endfunction

  // One clock: check outputs, let the edge pass, advance model
  task automatic step(output bit fired);
    bit   inf;
    bit   outf;
    bit   byp;
    exp_t e;
    #1;
    inf   = s_valid_i && s_ready_o;
    outf  = m_valid_o && m_ready_i;
    fired = inf;
    if (rst_i) begin
      check("rst_ready", s_ready_o, 0);
    end else begin
      if (flush_i) check("flush_ready", s_ready_o, 0);
      if (q.size() == 0) begin
        check("idle_valid", m_valid_o, 0);
        check("idle_sat", sat_o, 0);
      end else begin
        if (m_valid_o) begin
          check("data", int'($signed(m_data_o)), q[0].data);
          check("last", m_last_o, q[0].last);
        end
        check("sat", sat_o, outf && q[0].sat);
        if (outf) begin
          cap_d.push_back(int'($signed(m_data_o)));
          cap_l.push_back(m_last_o);
          cap_s.push_back(sat_o);
          if (lat_en) check("latency", cyc - q[0].cyc, 2);
          void'(q.pop_front());
        end
      end
    end
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
    end else begin
      if (flush_i) begin
        q.delete();
        midx = 0;
      end else if (inf) begin
        byp = (midx == 0) ? bypass_i : mbyp;
        if (midx == 0) mbyp = bypass_i;
        e = model_beat(int'($signed(s_data_i)), byp, mcoef[midx], midx);
        q.push_back(e);
        midx = (midx + 1) % N;
      end
      if (coef_we_i) mcoef[coef_addr_i] = int'($signed(coef_data_i));
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run(int pv, int pr, bit rc);
    int guard;
    bit f;
    guard = 0;
    while (src.size() > 0 && guard < 3000) begin
      s_valid_i   = ($urandom_range(99) < pv);
      s_data_i    = DW'(src[0]);
      m_ready_i   = ($urandom_range(99) < pr);
      coef_we_i   = rc && ($urandom_range(7) == 0);
      coef_addr_i = AW'($urandom);
      coef_data_i = CW'($urandom);
      step(f);
      if (f) void'(src.pop_front());
      guard++;
    end
    s_valid_i = 1'b0;
    coef_we_i = 1'b0;
    check("run_done", src.size(), 0);
  endtask

  task automatic drain();
    int guard;
    bit f;
    guard = 0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    while (q.size() > 0 && guard < 50) begin
      step(f);
      guard++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic cap_clear();
    cap_d.delete();
    cap_l.delete();
    cap_s.delete();
  endtask

  task automatic wr_coef(int a, int d);
    bit f;
    coef_we_i   = 1'b1;
    coef_addr_i = AW'(a);
    coef_data_i = CW'(d);
    step(f);
    coef_we_i = 1'b0;
  endtask

  initial begin
    bit f;
    int in5[$];
    int ns;
    int nl;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    lat_en = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    step(f);
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_last", m_last_o, 0);
    check("rst_sat", sat_o, 0);
    step(f);
    rst_i = 1'b0;
    s_valid_i = 1'b0;

    // unity table, constant 0x4000, fixed latency
    cap_clear();
    lat_en = 1'b1;
    for (int i = 0; i < N; i++) src.push_back(16'h4000);
    run(100, 100, 0);
    drain();
    lat_en = 1'b0;
    check("t1_count", cap_d.size(), N);
    check("t1_first", cap_d[0], 16'h4000);
    check("t1_last14", cap_l[14], 0);
    check("t1_last15", cap_l[15], 1);

    // Hann table and ramp
    for (int n = 0; n < N; n++)
      wr_coef(n, int'(32767.0 * 0.5 *
        (1.0 - $cos(2.0 * 3.14159265358979 * n / N))));
    cap_clear();
    for (int n = 0; n < N; n++) src.push_back(n * 1500 - 11000);
    run(100, 100, 0);
    drain();
    check("hann_0", cap_d[0], 0);
    check("hann_8", cap_d[8], 8 * 1500 - 11000);

    // most negative sample times most negative coef
    wr_coef(3, -32768);
    cap_clear();
    for (int n = 0; n < N; n++)
      src.push_back(n == 3 ? -32768 : int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    drain();
    ns = 0;
    foreach (cap_s[i]) ns += cap_s[i];
    check("sat_data", cap_d[3], 32767);
    check("sat_flag", cap_s[3], 1);
    check("sat_count", ns, 1);

    // random handshakes and coef writes over 10 frames
    for (int n = 0; n < 10 * N; n++)
      src.push_back(int'($urandom_range(65535)) - 32768);
    run(50, 50, 1);
    drain();

    // bypass change mid-frame is ignored until next frame
    bypass_i = 1'b0;
    for (int n = 0; n < 5; n++) src.push_back(int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    bypass_i = 1'b1;
    for (int n = 0; n < 11; n++) src.push_back(int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    drain();
    cap_clear();
    for (int n = 0; n < N; n++) begin
      in5.push_back(int'($urandom_range(65535)) - 32768);
      src.push_back(in5[n]);
    end
    run(60, 70, 0);
    drain();
    check("byp_0", cap_d[0], in5[0]);
    check("byp_7", cap_d[7], in5[7]);
    check("byp_15", cap_d[15], in5[15]);
    bypass_i = 1'b0;
    for (int n = 0; n < N; n++) src.push_back(int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    drain();

    // flush with two samples in flight
    cap_clear();
    for (int n = 0; n < 7; n++) src.push_back(int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    flush_i   = 1'b1;
    step(f);
    check("flush_accept", f, 0);
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    check("flush_out", cap_d.size(), 5);
    cap_clear();
    for (int n = 0; n < N; n++) src.push_back(int'($urandom_range(65535)) - 32768);
    run(100, 100, 0);
    drain();
    nl = 0;
    foreach (cap_l[i]) nl += cap_l[i];
    check("flush_count", cap_d.size(), N);
    check("flush_last", cap_l[N-1], 1);
    check("flush_nlast", nl, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
